// File: rtl/eu_arbiter_if.sv
// eu_arbiter_if: bundles the requester, response and exponent-unit signals of eu_arbiter.
//   req_valid/req_ready/req_data : per-requester operand handshake (N lanes, W bits each)
//   rsp_valid/rsp_ready/rsp_data : per-requester response FIFO heads
//   eu_valid_in/eu_x/eu_out      : issue strobe, operand and result of the shared EU
//   busy                         : work in flight or responses pending
// Modport slave is the arbiter side; master is the requester/EU environment side.
interface eu_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 32
);
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [N*W-1:0] rsp_data;
    logic           eu_valid_in;
    logic [W-1:0]   eu_x;
    logic [W-1:0]   eu_out;
    logic           busy;

    modport master (
        output req_valid, req_data, rsp_ready, eu_out,
        input  req_ready, rsp_valid, rsp_data, eu_valid_in, eu_x, busy
    );

    modport slave (
        input  req_valid, req_data, rsp_ready, eu_out,
        output req_ready, rsp_valid, rsp_data, eu_valid_in, eu_x, busy
    );
endinterface

// File: rtl/eu_arbiter.sv
// eu_arbiter: shares one pipelined exponent unit (EU) between N requesters.
// Round-robin grant among requesters that hold a credit, a tag pipeline matching the EU
// latency, and one response FIFO per requester. Credits bound outstanding work per
// requester to the FIFO depth, so a FIFO can never overflow.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : eu_arbiter_if slave modport (request, response and EU signals)
module eu_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned W         = 32,
    parameter int unsigned EU_LAT    = 3,
    parameter int unsigned RSP_DEPTH = 2
) (
    input logic         clk,
    input logic         rst,
    eu_arbiter_if.slave bus
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

    logic [IW-1:0] rr_ptr_q;
    logic [EU_LAT-1:0] tag_vld_q;
    logic [IW-1:0] tag_id_q [EU_LAT];
    logic [CW-1:0] credit_q [N];
    logic [CW-1:0] cnt_q [N];
    logic [PW-1:0] rd_ptr_q [N];
    logic [PW-1:0] wr_ptr_q [N];
    logic [W-1:0]  mem_q [N][RSP_DEPTH];

    logic [N-1:0]  eligible;
    logic [N-1:0]  pop;
    logic [N-1:0]  wr_en;
    logic [N-1:0]  issue;
    logic [N-1:0]  nonempty;
    logic          gnt_valid;
    logic [IW-1:0] gnt_idx;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        eligible = '0;
        pop      = '0;
        wr_en    = '0;
        nonempty = '0;
        for (int unsigned i = 0; i < N; i++) begin
            nonempty[i] = (cnt_q[i] != '0);
            eligible[i] = bus.req_valid[i] && (credit_q[i] != '0);
            // rsp_ready on an empty FIFO is not a pop
            pop[i]      = nonempty[i] && bus.rsp_ready[i];
            wr_en[i]    = tag_vld_q[EU_LAT-1] && (tag_id_q[EU_LAT-1] == IW'(i));
        end
    end

    // First eligible requester at or after rr_ptr, wrapping; nothing granted under reset.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (int'(rr_ptr_q) + k) % N;
            if (!rst && !gnt_valid && eligible[IW'(idx)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(idx);
            end
        end
    end

    always_comb begin
        issue           = '0;
        bus.eu_valid_in = 1'b0;
        bus.eu_x        = '0;
        if (gnt_valid) begin
            issue[gnt_idx]  = 1'b1;
            bus.eu_valid_in = 1'b1;
            bus.eu_x        = bus.req_data[gnt_idx*W +: W];
        end
        bus.req_ready = issue;
    end

    always_comb begin
        bus.rsp_valid = nonempty;
        bus.rsp_data  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (nonempty[i]) begin
                bus.rsp_data[i*W +: W] = mem_q[i][rd_ptr_q[i]];
            end
        end
        bus.busy = (|tag_vld_q) || (|nonempty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            tag_vld_q <= '0;
            for (int unsigned s = 0; s < EU_LAT; s++) begin
                tag_id_q[s] <= '0;
            end
            for (int unsigned i = 0; i < N; i++) begin
                credit_q[i] <= CW'(RSP_DEPTH);
                cnt_q[i]    <= '0;
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
            end
        end else begin
            if (gnt_valid) begin
                rr_ptr_q <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            end
            // Tags shift every cycle so results line up with eu_out EU_LAT edges later.
            tag_vld_q[0] <= gnt_valid;
            tag_id_q[0]  <= gnt_idx;
            for (int unsigned s = 1; s < EU_LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
            for (int unsigned i = 0; i < N; i++) begin
                if (issue[i] && !pop[i]) begin
                    credit_q[i] <= credit_q[i] - 1'b1;
                end else if (!issue[i] && pop[i]) begin
                    credit_q[i] <= credit_q[i] + 1'b1;
                end
                if (wr_en[i]) begin
                    mem_q[i][wr_ptr_q[i]] <= bus.eu_out;
                    wr_ptr_q[i]           <= ptr_inc(wr_ptr_q[i]);
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
                end
                if (wr_en[i] && !pop[i]) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end else if (!wr_en[i] && pop[i]) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_chk
        a_no_overflow: assert property (@(posedge clk) disable iff (rst)
            !(wr_en[gi] && !pop[gi] && (cnt_q[gi] == CW'(RSP_DEPTH))));
        a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
            !(pop[gi] && (cnt_q[gi] == '0)));
        a_credit_range: assert property (@(posedge clk) disable iff (rst)
            (credit_q[gi] <= CW'(RSP_DEPTH)));
        a_issue_has_credit: assert property (@(posedge clk) disable iff (rst)
            !(issue[gi] && (credit_q[gi] == '0)));
    end
endmodule

// File: tb/tb_eu_arbiter.sv
// tb_eu_arbiter: directed bench for eu_arbiter with a behavioural EU model.
// The EU model returns x + 0x03F85597 after EU_LAT edges and emits a junk value on idle
// cycles, which must never reach a response FIFO.
module tb_eu_arbiter;
    localparam int unsigned N         = 4;
    localparam int unsigned W         = 32;
    localparam int unsigned EU_LAT    = 3;
    localparam int unsigned RSP_DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eu_arbiter_if #(.N(N), .W(W)) bus ();

    eu_arbiter #(
        .N(N), .W(W), .EU_LAT(EU_LAT), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [W-1:0] eu_f(input logic [W-1:0] x);
        return x + 32'h03F8_5597;
    endfunction

    logic [W-1:0] eu_pipe [EU_LAT];
    always @(posedge clk) begin
        eu_pipe[0] <= bus.eu_valid_in ? eu_f(bus.eu_x) : 32'hDEAD_BEEF;
        for (int s = 1; s < EU_LAT; s++) eu_pipe[s] <= eu_pipe[s-1];
    end
    assign bus.eu_out = eu_pipe[EU_LAT-1];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [W-1:0]   dv [N];
    logic [N-1:0]   er;
    logic [N*W-1:0] ed;
    int             acc;
    int             eg [16] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 3, 0, 1, 3, 0, 1};

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = '0;

        // Reset behaviour, including req_ready held low while rst is high
        tick();
        bus.req_valid = '1;
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_eu_valid", bus.eu_valid_in, 0);
        chk("rst_eu_x", bus.eu_x, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_busy", bus.busy, 0);
        tick();
        rst = 1'b0;
        bus.req_valid = '0;
        #1;
        chk("post_rst_rsp_valid", bus.rsp_valid, 0);
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_eu_valid", bus.eu_valid_in, 0);

        // Single op on requester 0 with x = 0
        bus.rsp_ready = '1;
        bus.req_valid = 4'b0001;
        bus.req_data[0 +: W] = 32'h0;
        #1;
        chk("single_req_ready", bus.req_ready, 4'b0001);
        chk("single_eu_valid", bus.eu_valid_in, 1);
        chk("single_eu_x", bus.eu_x, 0);
        tick();
        bus.req_valid = '0;
        #1;
        chk("single_c1_rsp_valid", bus.rsp_valid, 0);
        chk("single_c1_busy", bus.busy, 1);
        tick();
        chk("single_c2_rsp_valid", bus.rsp_valid, 0);
        tick();
        chk("single_c3_rsp_valid", bus.rsp_valid, 0);
        tick();
        chk("single_c4_rsp_valid", bus.rsp_valid, 4'b0001);
        chk("single_c4_rsp_data", bus.rsp_data, {96'h0, 32'h03F8_5597});
        tick();
        chk("single_c5_rsp_valid", bus.rsp_valid, 0);
        chk("single_c5_busy", bus.busy, 0);

        // All four requesters streaming: grants 0,1,2,3,... and correct routing
        do_reset();
        bus.rsp_ready = '1;
        for (int i = 0; i < N; i++) begin
            dv[i] = 32'h0000_1000 * (i + 1);
            bus.req_data[i*W +: W] = dv[i];
        end
        for (int k = 0; k < 16; k++) begin
            bus.req_valid = (k < 12) ? '1 : '0;
            #1;
            er = '0;
            if (k < 12) er[k%4] = 1'b1;
            chk("rr_req_ready", bus.req_ready, er);
            chk("rr_eu_valid", bus.eu_valid_in, (k < 12) ? 1 : 0);
            chk("rr_eu_x", bus.eu_x, (k < 12) ? dv[k%4] : 0);
            er = '0;
            ed = '0;
            if (k >= 4) begin
                er[(k-4)%4] = 1'b1;
                ed[((k-4)%4)*W +: W] = eu_f(dv[(k-4)%4]);
            end
            chk("rr_rsp_valid", bus.rsp_valid, er);
            chk("rr_rsp_data", bus.rsp_data, ed);
            tick();
        end
        chk("rr_drained_busy", bus.busy, 0);

        // Credit stall on requester 2 while the others keep being served
        do_reset();
        bus.rsp_ready = 4'b1011;
        bus.req_valid = '1;
        acc = 0;
        for (int k = 0; k < 16; k++) begin
            bus.req_data[2*W +: W] = 32'h200 + k;
            #1;
            er = '0;
            er[eg[k]] = 1'b1;
            chk("stall_req_ready", bus.req_ready, er);
            acc += int'(bus.req_ready[2]);
            tick();
        end
        chk("stall_accepts2", acc, 2);
        bus.req_valid = 4'b0100;
        bus.req_data[2*W +: W] = 32'h210;
        #1;
        chk("stall_c16_req_ready", bus.req_ready, 0);
        chk("stall_c16_rsp_valid2", bus.rsp_valid[2], 1);
        chk("stall_c16_head", bus.rsp_data[2*W +: W], eu_f(32'h202));
        tick();
        bus.rsp_ready = 4'b1111;
        bus.req_data[2*W +: W] = 32'h211;
        #1;
        chk("stall_c17_req_ready", bus.req_ready, 0);
        chk("stall_c17_head", bus.rsp_data[2*W +: W], eu_f(32'h202));
        tick();
        bus.rsp_ready = 4'b1011;
        bus.req_data[2*W +: W] = 32'h212;
        #1;
        chk("stall_c18_head", bus.rsp_data[2*W +: W], eu_f(32'h206));
        chk("stall_c18_req_ready", bus.req_ready, 4'b0100);
        tick();
        bus.rsp_ready = 4'b1111;
        #1;
        chk("stall_c19_req_ready", bus.req_ready, 0);
        tick();
        chk("stall_c20_req_ready", bus.req_ready, 4'b0100);
        bus.req_valid = '0;
        repeat (8) tick();
        chk("stall_drain_busy", bus.busy, 0);
        chk("stall_drain_rsp_valid", bus.rsp_valid, 0);

        // Pop and write on the same edge: count held, order kept
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_data[1*W +: W] = 32'h0AAA_0000;
        #1;
        chk("sim_req_ready_a", bus.req_ready, 4'b0010);
        tick();
        bus.req_data[1*W +: W] = 32'h0BBB_0000;
        #1;
        chk("sim_req_ready_b", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        chk("sim_c4_rsp_valid", bus.rsp_valid, 4'b0010);
        chk("sim_c4_head", bus.rsp_data[1*W +: W], eu_f(32'h0AAA_0000));
        bus.rsp_ready = 4'b0010;
        tick();
        bus.rsp_ready = '0;
        #1;
        chk("sim_c5_rsp_valid", bus.rsp_valid, 4'b0010);
        chk("sim_c5_head", bus.rsp_data[1*W +: W], eu_f(32'h0BBB_0000));
        tick();
        chk("sim_c6_rsp_valid", bus.rsp_valid, 4'b0010);
        bus.rsp_ready = 4'b0010;
        tick();
        chk("sim_c7_rsp_valid", bus.rsp_valid, 0);
        chk("sim_c7_busy", bus.busy, 0);

        // Reset with three ops in flight
        do_reset();
        bus.rsp_ready = '1;
        bus.req_valid = 4'b0111;
        tick();
        tick();
        tick();
        rst = 1'b1;
        bus.req_valid = '0;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("midrst_late_rsp_valid", bus.rsp_valid, 0);
        end
        bus.rsp_ready = '0;
        bus.req_valid = 4'b0001;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            acc += int'(bus.req_ready[0]);
            tick();
        end
        chk("midrst_credit_accepts", acc, 2);

        // rr_ptr wrap: pointer at 3, only requester 1 valid
        do_reset();
        bus.rsp_ready = '1;
        bus.req_valid = 4'b0100;
        #1;
        chk("wrap_set_ptr3", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = 4'b0010;
        #1;
        chk("wrap_grant1", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = 4'b0110;
        #1;
        chk("wrap_ptr_now2", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/eu_arbiter.md
EU_ARBITER -- requirements
Module: eu_arbiter

Interface
REQ-001 The block SHALL expose parameter N, default 4: number of requesters sharing one exponent unit (EU).
REQ-002 The block SHALL expose parameter W, default 32: data width; Q5.26 signed in and out.
REQ-003 The block SHALL expose parameter EU_LAT, default 3: clock edges from an EU issue edge to the edge at which eu_out is sampled.
REQ-004 The block SHALL expose parameter RSP_DEPTH, default 2: response FIFO depth per requester.
REQ-005 The block SHALL provide clk  input  1  single clock; all state updates on rising edge.
REQ-006 The block SHALL provide rst  input  1  synchronous, active-high reset.
REQ-007 The block SHALL provide req_valid  input  N  per-requester operand valid.
REQ-008 The block SHALL provide req_ready  output  N  per-requester operand accepted this cycle.
REQ-009 The block SHALL provide req_data  input  N*W  operands, requester i in bits [i*W +: W].
REQ-010 The block SHALL provide rsp_valid  output  N  response FIFO i non-empty.
REQ-011 The block SHALL provide rsp_ready  input  N  requester i pops its response.
REQ-012 The block SHALL provide rsp_data  output  N*W  head of response FIFO i, same packing as req_data.
REQ-013 The block SHALL provide eu_valid_in  output  1  issue strobe to the EU.
REQ-014 The block SHALL provide eu_x  output  W  operand to the EU.
REQ-015 The block SHALL provide eu_out  input  W  EU result.
REQ-016 The block SHALL provide busy  output  1  any issue in flight or any response FIFO non-empty.

Function
REQ-017 Eligibility SHALL be: eligible[i] = req_valid[i] and credit[i] > 0.
REQ-018 Grant SHALL be round-robin and combinational: the first eligible index at or after rr_ptr, wrapping modulo N; at most one grant per cycle.
REQ-019 req_ready SHALL be one-hot on the granted index, otherwise all zero; req_ready SHALL NOT depend on rsp_ready.
REQ-020 On a grant, rr_ptr SHALL advance to (grant+1) mod N at the edge; with no grant, rr_ptr SHALL hold.
REQ-021 eu_valid_in SHALL be 1 and eu_x SHALL equal the granted req_data in the grant cycle; otherwise eu_valid_in = 0 and eu_x = 0.
REQ-022 A tag pipeline of EU_LAT stages SHALL carry {valid, requester id} from each issue edge, shifting every cycle regardless of new issues; back-to-back issues SHALL be supported.
REQ-023 When the final tag stage is valid, eu_out SHALL be written into FIFO[id] at that edge; rsp_valid[id] SHALL rise in the following cycle. End-to-end latency from req accept edge to rsp_valid is EU_LAT edges.
REQ-024 eu_out SHALL be ignored in cycles whose final tag stage is invalid.
REQ-025 Credit[i] SHALL decrement on issue to i and increment on pop (rsp_valid[i] and rsp_ready[i]); when both occur in the same cycle, credit[i] SHALL be unchanged.
REQ-026 Credit[i] SHALL stay within 0..RSP_DEPTH, guaranteeing FIFO[i] never overflows; overflow, and a pop while empty, SHALL be assertion-checked.
REQ-027 Each FIFO SHALL support a simultaneous write and pop in one cycle, including when full, and SHALL preserve per-requester issue order.
REQ-028 rsp_data slice i SHALL equal the FIFO[i] head, or 0 when FIFO[i] is empty; rsp_ready while empty SHALL be ignored.
REQ-029 A requester with credit 0 SHALL be skipped without stalling other requesters.

Reset
REQ-030 While rst = 1 at an edge: rr_ptr = 0, all tag stages invalid, all FIFOs empty, credit[i] = RSP_DEPTH.
REQ-031 During and immediately after reset: req_ready = 0 (while rst is high), rsp_valid = 0, rsp_data = 0, eu_valid_in = 0, eu_x = 0, busy = 0.
REQ-032 Reset mid-operation SHALL discard in-flight issues; eu_out values that emerge after reset SHALL NOT be written to any FIFO.

Verification
REQ-033 Single op: requester 0 sends x=0x00000000 and rsp_ready=1 -> req_ready[0] high for 1 cycle; rsp_valid[0] high EU_LAT edges later; rsp_data[0] = 0x03F85597.
REQ-034 All four requesters hold req_valid=1 continuously with rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; eu_valid_in constantly 1; each response is routed to the correct requester.
REQ-035 Credit stall: requester 2 streams with rsp_ready[2]=0 -> exactly RSP_DEPTH=2 accepts, then req_ready[2] stays 0 while other requesters keep being served; raising rsp_ready[2] restores one credit per pop.
REQ-036 Full FIFO with pop and write in the same cycle -> count unchanged and order preserved, with no overflow assertion.
REQ-037 Assert rst while 3 ops are in flight -> no rsp_valid afterwards, credits reset to 2, busy = 0 on the first cycle after reset.
REQ-038 rr_ptr wrap: rr_ptr=3 with only requester 1 valid -> grant 1, and rr_ptr becomes 2.
